// File: rtl/game_flow_ctrl_pkg.sv
// game_flow_ctrl_pkg: game flow states, game_active encodings and counter sizing shared across the game.
package game_flow_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_MENU,
        ST_COUNTDOWN,
        ST_PLAYING,
        ST_PAUSED,
        ST_LOST,
        ST_WON
    } game_state_t;

    localparam logic [1:0] GA_IDLE = 2'd0;
    localparam logic [1:0] GA_PLAY = 2'd1;
    localparam logic [1:0] GA_LOST = 2'd2;
    localparam logic [1:0] GA_WON  = 2'd3;

    function automatic int cnt_w(input int a, input int b);
        int m;
        m = a > b ? a : b;
        return m < 2 ? 1 : $clog2(m);
    endfunction

    function automatic logic [1:0] ga_of(input game_state_t s);
        return s == ST_PLAYING ? GA_PLAY : s == ST_LOST ? GA_LOST : s == ST_WON ? GA_WON : GA_IDLE;
    endfunction
endpackage

// File: rtl/edge_det.sv
// edge_det: one-cycle pulse on each rising edge of a synchronous level.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);
    logic d_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) d_q <= 1'b0;
        else      d_q <= d_i;

    assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: menu/countdown/play/pause/game-over sequencing with registered outputs.
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int OVER_HOLD_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       player2_game_start,
    input  logic       player_dead,
    input  logic       boss_dead,
    output logic [1:0] game_active,
    output logic       game_start,
    output logic [1:0] countdown,
    output logic       paused
);
    localparam int CW = cnt_w(COUNTDOWN_FRAMES, OVER_HOLD_FRAMES);
    localparam logic [CW-1:0] CD_LOAD = CW'(COUNTDOWN_FRAMES - 1);
    localparam logic [CW-1:0] OH_LOAD = CW'(OVER_HOLD_FRAMES - 1);
    localparam logic [CW-1:0] TH3     = CW'(2 * COUNTDOWN_FRAMES / 3);
    localparam logic [CW-1:0] TH2     = CW'(COUNTDOWN_FRAMES / 3);

    game_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_rise, pause_rise, start_ev;

    edge_det u_start (.clk(clk), .rst(rst), .d_i(btn_start), .rise_o(start_rise));
    edge_det u_pause (.clk(clk), .rst(rst), .d_i(btn_pause), .rise_o(pause_rise));

    assign start_ev = start_rise | player2_game_start;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_MENU: if (start_ev) begin
                state_d = ST_COUNTDOWN;
                cnt_d   = CD_LOAD;
            end
            ST_COUNTDOWN: if (frame_tick) begin
                if (cnt_q == '0) state_d = ST_PLAYING;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_PLAYING: begin
                if (player_dead || boss_dead) cnt_d = OH_LOAD;
                state_d = player_dead ? ST_LOST : boss_dead ? ST_WON : pause_rise ? ST_PAUSED : ST_PLAYING;
            end
            ST_PAUSED: state_d = pause_rise ? ST_PLAYING : start_rise ? ST_MENU : ST_PAUSED;
            ST_LOST, ST_WON: begin
                if (start_ev && cnt_q == '0)      state_d = ST_MENU;
                else if (frame_tick && cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            default: state_d = ST_MENU;
        endcase
    end

    // Outputs are decoded from next state so they line up with the registered state.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q     <= ST_MENU;
            cnt_q       <= '0;
            game_active <= GA_IDLE;
            game_start  <= 1'b0;
            countdown   <= 2'd0;
            paused      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            game_active <= ga_of(state_d);
            game_start  <= state_q == ST_MENU && state_d == ST_COUNTDOWN;
            countdown   <= state_d != ST_COUNTDOWN ? 2'd0 : cnt_d >= TH3 ? 2'd3 : cnt_d >= TH2 ? 2'd2 : 2'd1;
            paused      <= state_d == ST_PAUSED;
        end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed vectors over menu, countdown, pause, game-over and reset behaviour.
module tb_game_flow_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0, btn_start = 1'b0, btn_pause = 1'b0;
    logic       player2_game_start = 1'b0, player_dead = 1'b0, boss_dead = 1'b0;
    logic [1:0] game_active, countdown;
    logic       game_start, paused;
    int         n_vec = 0, n_err = 0, n_gs;

    game_flow_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_start(btn_start),
        .btn_pause(btn_pause), .player2_game_start(player2_game_start),
        .player_dead(player_dead), .boss_dead(boss_dead), .game_active(game_active),
        .game_start(game_start), .countdown(countdown), .paused(paused)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
        end
    endtask

    task automatic outs(input string tag, input int ga, input int gs, input int cd, input int pz);
        check({tag, ".game_active"}, game_active, ga);
        check({tag, ".game_start"}, game_start, gs);
        check({tag, ".countdown"}, countdown, cd);
        check({tag, ".paused"}, paused, pz);
    endtask

    initial begin
        #23;
        outs("in_reset", 0, 0, 0, 0);
        cyc();
        rst = 1'b1;
        cyc();
        outs("menu", 0, 0, 0, 0);
        btn_start = 1'b1;
        cyc();
        outs("start", 0, 1, 3, 0);
        cyc();
        check("gs_one_cycle", game_start, 0);
        btn_start = 1'b0;
        ticks(59);
        outs("cd_120", 0, 0, 3, 0);
        ticks(1);
        check("cd_119", countdown, 2);
        ticks(59);
        check("cd_60", countdown, 2);
        ticks(1);
        check("cd_59", countdown, 1);
        ticks(59);
        outs("cd_0", 0, 0, 1, 0);
        ticks(1);
        outs("playing", 1, 0, 0, 0);
        btn_pause = 1'b1;
        cyc();
        outs("pause", 0, 0, 0, 1);
        player_dead = 1'b1;
        repeat (3) cyc();
        outs("pause_dead", 0, 0, 0, 1);
        player_dead = 1'b0;
        btn_pause = 1'b0;
        cyc();
        btn_pause = 1'b1;
        cyc();
        outs("resume", 1, 0, 0, 0);
        btn_pause = 1'b0;
        btn_start = 1'b1;
        cyc();
        outs("start_in_play", 1, 0, 0, 0);
        btn_start = 1'b0;
        player2_game_start = 1'b1;
        cyc();
        player2_game_start = 1'b0;
        check("p2_in_play", game_active, 1);
        player_dead = 1'b1;
        boss_dead = 1'b1;
        cyc();
        player_dead = 1'b0;
        boss_dead = 1'b0;
        outs("both_dead", 2, 0, 0, 0);
        ticks(119);
        btn_start = 1'b1;
        cyc();
        btn_start = 1'b0;
        check("lost_to_menu", game_active, 0);
        cyc();
        n_gs = 0;
        btn_start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            n_gs += int'(game_start);
        end
        btn_start = 1'b0;
        check("held_start_pulses", n_gs, 1);
        ticks(180);
        check("play2", game_active, 1);
        boss_dead = 1'b1;
        cyc();
        boss_dead = 1'b0;
        check("won", game_active, 3);
        ticks(50);
        btn_start = 1'b1;
        cyc();
        btn_start = 1'b0;
        check("won_early_start", game_active, 3);
        ticks(70);
        btn_start = 1'b1;
        cyc();
        btn_start = 1'b0;
        outs("won_to_menu", 0, 0, 0, 0);
        player2_game_start = 1'b1;
        cyc();
        player2_game_start = 1'b0;
        outs("p2_start", 0, 1, 3, 0);
        ticks(10);
        #2 rst = 1'b0;
        #1;
        outs("async_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc();
        outs("after_rst", 0, 0, 0, 0);
        btn_start = 1'b1;
        cyc();
        btn_start = 1'b0;
        check("restart_gs", game_start, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
